regfile_wb: RTL and testbench

- General-purpose register file at the consumer end of the writeback interface.
- Accepts one write per cycle from the MEM/WB pipeline register outputs (write enable, address, data).
- Serves two read ports to the ID stage, with same-cycle write-to-read bypass so a value being written back is visible to the instruction being decoded in that cycle.
- r0 is hardwired to zero.

---
 rtl/regfile_wb_pkg.sv | 14 +
 rtl/regfile_rd_port.sv | 29 ++
 rtl/regfile_wb.sv | 98 +++++++++
 tb/tb_regfile_wb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared widths and control encodings for the writeback register file
package regfile_wb_pkg;
  localparam int RegBusW     = 32;
  localparam int RegAddrBusW = 5;

  localparam logic [RegBusW-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBusW-1:0] NOPRegAddr = '0;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with r0 masking and writeback bypass
module regfile_rd_port
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = RegBusW,
  parameter int ADDR_W = RegAddrBusW
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = '0;
    if (rst != RstEnable && raddr != ADDR_W'(NOPRegAddr) && re == ReadEnable) begin
      if (wb_we == WriteEnable && wb_waddr == raddr) begin
        rdata = wb_wdata;
      end else begin
        rdata = mem_rdata;
      end
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - GPR file with two bypassed read ports; REGFILE_HILO_EN adds a HI/LO pair
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W   = RegBusW,
  parameter int ADDR_W   = RegAddrBusW,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
`ifdef REGFILE_HILO_EN
  ,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata
`endif
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_comb begin
    mem_d = mem_q;
    if (wb_we == WriteEnable && wb_waddr != ADDR_W'(NOPRegAddr)) begin
      mem_d[wb_waddr] = wb_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .rst      (rst),
    .re       (re1),
    .raddr    (raddr1),
    .wb_we    (wb_we),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .mem_rdata(mem_q[raddr1]),
    .rdata    (rdata1)
  );

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .rst      (rst),
    .re       (re2),
    .raddr    (raddr2),
    .wb_we    (wb_we),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .mem_rdata(mem_q[raddr2]),
    .rdata    (rdata2)
  );

`ifdef REGFILE_HILO_EN
  logic [2*DATA_W-1:0] hilo_q;
  logic [2*DATA_W-1:0] hilo_d;

  assign hilo_d = (hilo_we == WriteEnable) ? {hi_wdata, lo_wdata} : hilo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      hilo_q <= '0;
    end else begin
      hilo_q <= hilo_d;
    end
  end

  // HI/LO behaves as a single always-enabled register at a fixed nonzero address.
  regfile_rd_port #(.DATA_W(2 * DATA_W), .ADDR_W(ADDR_W)) u_rd_hilo (
    .rst      (rst),
    .re       (ReadEnable),
    .raddr    (ADDR_W'(1)),
    .wb_we    (hilo_we),
    .wb_waddr (ADDR_W'(1)),
    .wb_wdata ({hi_wdata, lo_wdata}),
    .mem_rdata(hilo_q),
    .rdata    ({hi_rdata, lo_rdata})
  );
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - self-checking bench for regfile_wb; REGFILE_HILO_EN enables HI/LO tests
module tb_regfile_wb;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_we = 1'b0;
  logic [AW-1:0] wb_waddr = '0;
  logic [DW-1:0] wb_wdata = '0;
  logic          re1 = 1'b0;
  logic [AW-1:0] raddr1 = '0;
  logic [DW-1:0] rdata1;
  logic          re2 = 1'b0;
  logic [AW-1:0] raddr2 = '0;
  logic [DW-1:0] rdata2;
`ifdef REGFILE_HILO_EN
  logic          hilo_we = 1'b0;
  logic [DW-1:0] hi_wdata = '0;
  logic [DW-1:0] lo_wdata = '0;
  logic [DW-1:0] hi_rdata;
  logic [DW-1:0] lo_rdata;
  logic [DW-1:0] hi_m = '0;
  logic [DW-1:0] lo_m = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic cmp_en = 1'b0;
  logic [DW-1:0] model [32];

  regfile_wb dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
`ifdef REGFILE_HILO_EN
    , .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: a plain array updated by the write rule, cleared by reset.
  initial for (int i = 0; i < 32; i++) model[i] = '0;

  always @(posedge rst) begin
    for (int i = 0; i < 32; i++) model[i] = '0;
`ifdef REGFILE_HILO_EN
    hi_m = '0;
    lo_m = '0;
`endif
  end

  always @(posedge clk) begin
    if (!rst && wb_we && wb_waddr != 0) model[wb_waddr] = wb_wdata;
`ifdef REGFILE_HILO_EN
    if (!rst && hilo_we) begin
      hi_m = hi_wdata;
      lo_m = lo_wdata;
    end
`endif
  end

  function automatic logic [DW-1:0] exp_rd(input logic re, input logic [AW-1:0] a);
    if (rst) return '0;
    if (a == 0) return '0;
    if (!re) return '0;
    if (wb_we && wb_waddr == a) return wb_wdata;
    return model[a];
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_rdata1", rdata1, exp_rd(re1, raddr1));
      check("cmp_rdata2", rdata2, exp_rd(re2, raddr2));
`ifdef REGFILE_HILO_EN
      check("cmp_hi", hi_rdata, rst ? '0 : (hilo_we ? hi_wdata : hi_m));
      check("cmp_lo", lo_rdata, rst ? '0 : (hilo_we ? lo_wdata : lo_m));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_we = 1'b1;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  initial begin
    re1 = 1'b1;
    raddr1 = 5;
    tick();
    cmp_en = 1'b1;
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_rdata2", rdata2, 32'h0);
    rst = 1'b0;
    tick();

    // r5 write, then async reset clears it without a clock edge
    wr(5, 32'h12345678);
    #1 check("r5_bypass", rdata1, 32'h12345678);
    tick();
    wb_we = 1'b0;
    #1 check("r5_stored", rdata1, 32'h12345678);
    rst = 1'b1;
    #1 check("r5_during_rst", rdata1, 32'h0);
    rst = 1'b0;
    #1 check("r5_after_rst", rdata1, 32'h0);
    tick();

    wr(7, 32'hDEADBEEF);
    tick();
    wb_we = 1'b0;
    raddr1 = 7;
    #1 check("r7_readback", rdata1, 32'hDEADBEEF);
    tick();

    wr(3, 32'hA5A5A5A5);
    raddr1 = 3;
    raddr2 = 3;
    re2 = 1'b1;
    #1 check("bypass_p1", rdata1, 32'hA5A5A5A5);
    check("bypass_p2", rdata2, 32'hA5A5A5A5);
    tick();
    wb_we = 1'b0;
    #1 check("r3_stored_p2", rdata2, 32'hA5A5A5A5);

    wr(0, 32'hFFFFFFFF);
    raddr1 = 0;
    raddr2 = 0;
    #1 check("r0_inflight", rdata1, 32'h0);
    tick();
    wb_we = 1'b0;
    #1 check("r0_after", rdata1, 32'h0);
    check("r0_after_p2", rdata2, 32'h0);

    wr(9, 32'h00000042);
    tick();
    wb_we = 1'b0;
    re2 = 1'b0;
    raddr2 = 9;
    #1 check("re2_off", rdata2, 32'h0);
    re2 = 1'b1;
    #1 check("re2_on", rdata2, 32'h00000042);
    tick();

    // write coinciding with reset is lost; first write after release lands
    rst = 1'b1;
    wr(10, 32'h00000055);
    tick();
    rst = 1'b0;
    wb_we = 1'b0;
    raddr1 = 10;
    #1 check("lost_under_rst", rdata1, 32'h0);
    check("r9_cleared", rdata2, 32'h0);
    wr(10, 32'h00000066);
    tick();
    wb_we = 1'b0;
    #1 check("first_after_rst", rdata1, 32'h00000066);

    wr(10, 32'h00000077);
    raddr2 = 10;
    re2 = 1'b0;
    #1 check("bypass_over_old", rdata1, 32'h00000077);
    check("bypass_re_off", rdata2, 32'h0);
    tick();

    for (int i = 1; i < 32; i++) begin
      wr(AW'(i), (32'h01000193 * i) ^ 32'hC3);
      raddr1 = AW'(i);
      raddr2 = AW'(i - 1);
      re2 = 1'b1;
      tick();
    end
    wb_we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = AW'(i);
      raddr2 = AW'(31 - i);
      re1 = (i % 3) != 0;
      re2 = i[0];
      tick();
    end
    re1 = 1'b1;
    raddr1 = 31;
    #1 check("sweep_r31", rdata1, 32'h1F00300E);

`ifdef REGFILE_HILO_EN
    hilo_we = 1'b1;
    hi_wdata = 32'h1;
    lo_wdata = 32'h2;
    #1 check("hi_bypass", hi_rdata, 32'h1);
    check("lo_bypass", lo_rdata, 32'h2);
    tick();
    hilo_we = 1'b0;
    hi_wdata = 32'hFFFF;
    lo_wdata = 32'hEEEE;
    #1 check("hi_persist", hi_rdata, 32'h1);
    check("lo_persist", lo_rdata, 32'h2);
    tick();
    rst = 1'b1;
    #1 check("hi_rst", hi_rdata, 32'h0);
    check("lo_rst", lo_rdata, 32'h0);
    rst = 1'b0;
    #1 check("hi_after_rst", hi_rdata, 32'h0);
    check("lo_after_rst", lo_rdata, 32'h0);
    tick();
`endif

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
